// File: rtl/orientation_sequencer_pkg.sv
// Shared definitions for the orientation sequencer: FSM state encoding,
// heading constants, polar-fix field positions and the heading wrap helper.
package orientation_sequencer_pkg;

    // Heading is an index in 15 degree steps, so a full turn is 24 steps.
    localparam int ORIENT_W = 5;
    localparam int RTHETA_W = 12;
    localparam logic [ORIENT_W-1:0] DEG360 = 5'd24;

    // Polar fix layout: radius in the low byte, theta index in the top nibble.
    localparam int R_LSB     = 0;
    localparam int R_MSB     = 7;
    localparam int THETA_LSB = 8;
    localparam int THETA_MSB = 11;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_GET_ORIG   = 4'd1,
        ST_MOVE       = 4'd2,
        ST_SETTLE     = 4'd3,
        ST_GET_FINAL  = 4'd4,
        ST_MATH_START = 4'd5,
        ST_MATH_ARM   = 4'd6,
        ST_MATH_WAIT  = 4'd7,
        ST_REPORT     = 4'd8
    } seq_state_t;

    // The math engine can return up to 31; one subtraction of a full turn
    // is always enough to land back in 0..23.
    function automatic logic [ORIENT_W-1:0] reduce_heading(input logic [ORIENT_W-1:0] raw);
        if (raw >= DEG360) begin
            return raw - DEG360;
        end
        return raw;
    endfunction

endpackage

// File: rtl/orientation_sequencer_counter.sv
// Shared down-counter used for the post-move settle delay and, when the
// ORIENT_TIMEOUT_EN build option is enabled, for the per-state watchdog.
// Load wins over decrement; the count holds once it reaches zero.
module seq_down_counter #(
    parameter int CNT_W = 26
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Count register: reload on request, otherwise step down towards zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/orientation_sequencer.sv
// Top-level sequencer for one robot heading measurement: first fix, move,
// settle, second fix, math engine handshake, registered heading result.
// Build option ORIENT_TIMEOUT_EN adds a watchdog on every waiting state that
// aborts the measurement and raises the sticky timeout_err flag.
module orientation_sequencer
    import orientation_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2_700_000,
    parameter int TIMEOUT_CYCLES = 54_000_000,
    parameter int CNT_W          = 26
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                loc_valid,
    input  logic [RTHETA_W-1:0] loc_r_theta,
    output logic                move_req,
    input  logic                move_done,
    output logic                math_enable,
    output logic [RTHETA_W-1:0] math_r_theta_orig,
    output logic [RTHETA_W-1:0] math_r_theta_final,
    input  logic                math_done,
    input  logic [ORIENT_W-1:0] math_orientation,
    output logic [ORIENT_W-1:0] orientation,
    output logic                orient_valid,
    output logic                busy,
    output logic                timeout_err
);

    // A requested delay of 0 or 1 still gives a single settle cycle.
    localparam logic [CNT_W-1:0] SETTLE_LOAD =
        (SETTLE_CYCLES <= 1) ? '0 : CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD =
        (TIMEOUT_CYCLES <= 1) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t state, next_state;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_value;
    logic             cnt_dec;
    logic             cnt_zero;

    logic capture_orig;
    logic capture_final;
    logic capture_result;
    logic start_accept;
`ifdef ORIENT_TIMEOUT_EN
    logic timeout_hit;
`endif

    seq_down_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    // State register; reset aborts any measurement in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and strobe decode. The watchdog reload on entry to each
    // waiting state is harmless without the watchdog: the only other user,
    // SETTLE, always reloads the counter on its own entry.
    always_comb begin
        next_state     = state;
        cnt_load       = 1'b0;
        cnt_load_value = TIMEOUT_LOAD;
        cnt_dec        = 1'b0;
        capture_orig   = 1'b0;
        capture_final  = 1'b0;
        capture_result = 1'b0;
        start_accept   = 1'b0;
`ifdef ORIENT_TIMEOUT_EN
        timeout_hit    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    cnt_load     = 1'b1;
                    next_state   = ST_GET_ORIG;
                end
            end
            ST_GET_ORIG: begin
                if (loc_valid) begin
                    capture_orig = 1'b1;
                    cnt_load     = 1'b1;
                    next_state   = ST_MOVE;
                end
`ifdef ORIENT_TIMEOUT_EN
                else if (cnt_zero) begin
                    timeout_hit = 1'b1;
                    next_state  = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
`endif
            end
            ST_MOVE: begin
                if (move_done) begin
                    cnt_load       = 1'b1;
                    cnt_load_value = SETTLE_LOAD;
                    next_state     = ST_SETTLE;
                end
`ifdef ORIENT_TIMEOUT_EN
                else if (cnt_zero) begin
                    timeout_hit = 1'b1;
                    next_state  = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
`endif
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    cnt_load   = 1'b1;
                    next_state = ST_GET_FINAL;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_GET_FINAL: begin
                if (loc_valid) begin
                    capture_final = 1'b1;
                    next_state    = ST_MATH_START;
                end
`ifdef ORIENT_TIMEOUT_EN
                else if (cnt_zero) begin
                    timeout_hit = 1'b1;
                    next_state  = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
`endif
            end
            ST_MATH_START: begin
                cnt_load   = 1'b1;
                next_state = ST_MATH_ARM;
            end
            ST_MATH_ARM: begin
                if (!math_done) begin
                    cnt_load   = 1'b1;
                    next_state = ST_MATH_WAIT;
                end
`ifdef ORIENT_TIMEOUT_EN
                else if (cnt_zero) begin
                    timeout_hit = 1'b1;
                    next_state  = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
`endif
            end
            ST_MATH_WAIT: begin
                if (math_done) begin
                    capture_result = 1'b1;
                    next_state     = ST_REPORT;
                end
`ifdef ORIENT_TIMEOUT_EN
                else if (cnt_zero) begin
                    timeout_hit = 1'b1;
                    next_state  = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
`endif
            end
            ST_REPORT: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Captured fixes and heading result hold until overwritten by a later run.
    always_ff @(posedge clock) begin
        if (reset) begin
            math_r_theta_orig  <= '0;
            math_r_theta_final <= '0;
            orientation        <= '0;
        end else begin
            if (capture_orig) begin
                math_r_theta_orig <= loc_r_theta;
            end
            if (capture_final) begin
                math_r_theta_final <= loc_r_theta;
            end
            if (capture_result) begin
                orientation <= reduce_heading(math_orientation);
            end
        end
    end

`ifdef ORIENT_TIMEOUT_EN
    // Sticky watchdog flag, cleared only when a new measurement is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (start_accept) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    assign move_req     = (state == ST_MOVE);
    assign math_enable  = (state == ST_MATH_START);
    assign orient_valid = (state == ST_REPORT);
    assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_orientation_sequencer.sv
// Directed self-checking bench for orientation_sequencer. Inputs change 1ns
// after each rising edge and outputs are sampled at the same point, so every
// check sees the state entered on the preceding edge.
// Build option ORIENT_TIMEOUT_EN selects the watchdog scenario.
module tb_orientation_sequencer;

    localparam int SETTLE = 5;
    localparam int TMO    = 100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        loc_valid = 1'b0;
    logic [11:0] loc_r_theta = '0;
    logic        move_done = 1'b0;
    logic        math_done = 1'b0;
    logic [4:0]  math_orientation = '0;
    logic        move_req;
    logic        math_enable;
    logic [11:0] orig_q;
    logic [11:0] final_q;
    logic [4:0]  orientation;
    logic        orient_valid;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int fails = 0;
    int en_cycles = 0;
    int valid_pulses = 0;

    always #5 clock = ~clock;

    orientation_sequencer #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (26)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .loc_valid          (loc_valid),
        .loc_r_theta        (loc_r_theta),
        .move_req           (move_req),
        .move_done          (move_done),
        .math_enable        (math_enable),
        .math_r_theta_orig  (orig_q),
        .math_r_theta_final (final_q),
        .math_done          (math_done),
        .math_orientation   (math_orientation),
        .orientation        (orientation),
        .orient_valid       (orient_valid),
        .busy               (busy),
        .timeout_err        (timeout_err)
    );

    // Advance one clock and tally the pulse outputs seen in the new cycle.
    task automatic step();
        @(posedge clock);
        #1;
        if (math_enable === 1'b1) en_cycles++;
        if (orient_valid === 1'b1) valid_pulses++;
    endtask

    // Drive a full measurement up to the first MATH_WAIT cycle (or MATH_ARM
    // if math_done is still high from an earlier run).
    task automatic run_to_wait(input logic [11:0] fix_a, input logic [11:0] fix_b);
        start = 1'b1; step(); start = 1'b0;
        loc_r_theta = fix_a; loc_valid = 1'b1; step(); loc_valid = 1'b0;
        step(); step();
        move_done = 1'b1; step(); move_done = 1'b0;
        repeat (SETTLE) step();
        loc_r_theta = fix_b; loc_valid = 1'b1; step(); loc_valid = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; step(); step();
        checks++; if (move_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_move_req: got %b expected 0", move_req); end
        checks++; if (math_enable !== 1'b0) begin fails++; $display("[TB] FAIL reset_math_enable: got %b expected 0", math_enable); end
        checks++; if (orig_q !== 12'h000) begin fails++; $display("[TB] FAIL reset_orig: got %h expected 000", orig_q); end
        checks++; if (final_q !== 12'h000) begin fails++; $display("[TB] FAIL reset_final: got %h expected 000", final_q); end
        checks++; if (orientation !== 5'd0) begin fails++; $display("[TB] FAIL reset_orientation: got %0d expected 0", orientation); end
        checks++; if (orient_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_orient_valid: got %b expected 0", orient_valid); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (timeout_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_timeout_err: got %b expected 0", timeout_err); end
        reset = 1'b0; step();
    endtask

    task automatic test_basic();
        valid_pulses = 0; en_cycles = 0;
        run_to_wait(12'h340, 12'h360);
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL basic_busy: got %b expected 1", busy); end
        checks++; if (orig_q !== 12'h340) begin fails++; $display("[TB] FAIL basic_orig: got %h expected 340", orig_q); end
        checks++; if (final_q !== 12'h360) begin fails++; $display("[TB] FAIL basic_final: got %h expected 360", final_q); end
        checks++; if (valid_pulses !== 0) begin fails++; $display("[TB] FAIL basic_early_valid: got %0d expected 0", valid_pulses); end
        math_orientation = 5'd3; math_done = 1'b1; step();
        checks++; if (orientation !== 5'd3) begin fails++; $display("[TB] FAIL basic_orientation: got %0d expected 3", orientation); end
        checks++; if (orient_valid !== 1'b1) begin fails++; $display("[TB] FAIL basic_valid_high: got %b expected 1", orient_valid); end
        math_done = 1'b0; step();
        checks++; if (orient_valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_valid_low: got %b expected 0", orient_valid); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL basic_idle: got %b expected 0", busy); end
        checks++; if (valid_pulses !== 1) begin fails++; $display("[TB] FAIL basic_valid_count: got %0d expected 1", valid_pulses); end
        checks++; if (en_cycles !== 1) begin fails++; $display("[TB] FAIL basic_enable_width: got %0d expected 1", en_cycles); end
    endtask

    task automatic test_stale_done();
        valid_pulses = 0; en_cycles = 0;
        math_done = 1'b1; math_orientation = 5'd9;
        run_to_wait(12'h111, 12'h222);
        repeat (3) step();
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL stale_busy: got %b expected 1", busy); end
        checks++; if (valid_pulses !== 0) begin fails++; $display("[TB] FAIL stale_no_result: got %0d expected 0", valid_pulses); end
        math_done = 1'b0; step();
        checks++; if (valid_pulses !== 0) begin fails++; $display("[TB] FAIL stale_after_fall: got %0d expected 0", valid_pulses); end
        math_done = 1'b1; step();
        checks++; if (orient_valid !== 1'b1) begin fails++; $display("[TB] FAIL stale_valid: got %b expected 1", orient_valid); end
        checks++; if (orientation !== 5'd9) begin fails++; $display("[TB] FAIL stale_orientation: got %0d expected 9", orientation); end
        math_done = 1'b0; step();
        checks++; if (en_cycles !== 1) begin fails++; $display("[TB] FAIL stale_enable_width: got %0d expected 1", en_cycles); end
        checks++; if (valid_pulses !== 1) begin fails++; $display("[TB] FAIL stale_valid_count: got %0d expected 1", valid_pulses); end
    endtask

    task automatic test_range();
        logic [4:0] raw_tab [3];
        logic [4:0] exp_tab [3];
        raw_tab[0] = 5'd26; exp_tab[0] = 5'd2;
        raw_tab[1] = 5'd24; exp_tab[1] = 5'd0;
        raw_tab[2] = 5'd31; exp_tab[2] = 5'd7;
        for (int i = 0; i < 3; i++) begin
            run_to_wait(12'h100 + 12'(i), 12'h200 + 12'(i));
            math_orientation = raw_tab[i]; math_done = 1'b1; step();
            checks++; if (orientation !== exp_tab[i]) begin fails++; $display("[TB] FAIL range_%0d: got %0d expected %0d", raw_tab[i], orientation, exp_tab[i]); end
            math_done = 1'b0; step();
        end
    endtask

    task automatic test_ignored();
        valid_pulses = 0;
        start = 1'b1; step(); start = 1'b0;
        loc_r_theta = 12'h155; loc_valid = 1'b1; step(); loc_valid = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        checks++; if (move_req !== 1'b1) begin fails++; $display("[TB] FAIL ignore_start_in_move: got %b expected 1", move_req); end
        move_done = 1'b1; step(); move_done = 1'b0;
        loc_r_theta = 12'hAAA; loc_valid = 1'b1; start = 1'b1; step(); loc_valid = 1'b0; start = 1'b0;
        step(); step();
        loc_r_theta = 12'hBBB; loc_valid = 1'b1; step();
        loc_r_theta = 12'hCCC; step(); loc_valid = 1'b0;
        step(); step();
        checks++; if (math_enable !== 1'b0) begin fails++; $display("[TB] FAIL ignore_no_enable: got %b expected 0", math_enable); end
        checks++; if (final_q !== 12'h202) begin fails++; $display("[TB] FAIL ignore_settle_fix: got %h expected 202", final_q); end
        loc_r_theta = 12'h3C5; loc_valid = 1'b1; step(); loc_valid = 1'b0;
        checks++; if (math_enable !== 1'b1) begin fails++; $display("[TB] FAIL ignore_enable: got %b expected 1", math_enable); end
        checks++; if (final_q !== 12'h3C5) begin fails++; $display("[TB] FAIL ignore_final: got %h expected 3c5", final_q); end
        checks++; if (orig_q !== 12'h155) begin fails++; $display("[TB] FAIL ignore_orig: got %h expected 155", orig_q); end
        start = 1'b1; step(); start = 1'b0;
        step();
        math_orientation = 5'd23; math_done = 1'b1; step();
        checks++; if (orientation !== 5'd23) begin fails++; $display("[TB] FAIL ignore_orientation: got %0d expected 23", orientation); end
        math_done = 1'b0; step();
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL ignore_idle: got %b expected 0", busy); end
        checks++; if (valid_pulses !== 1) begin fails++; $display("[TB] FAIL ignore_valid_count: got %0d expected 1", valid_pulses); end
    endtask

    task automatic test_reset_abort();
        start = 1'b1; step(); start = 1'b0;
        loc_r_theta = 12'h0F0; loc_valid = 1'b1; step(); loc_valid = 1'b0;
        checks++; if (move_req !== 1'b1) begin fails++; $display("[TB] FAIL abort_in_move: got %b expected 1", move_req); end
        reset = 1'b1; step();
        checks++; if (move_req !== 1'b0) begin fails++; $display("[TB] FAIL abort_move_req: got %b expected 0", move_req); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (orig_q !== 12'h000) begin fails++; $display("[TB] FAIL abort_orig: got %h expected 000", orig_q); end
        checks++; if (final_q !== 12'h000) begin fails++; $display("[TB] FAIL abort_final: got %h expected 000", final_q); end
        checks++; if (orientation !== 5'd0) begin fails++; $display("[TB] FAIL abort_orientation: got %0d expected 0", orientation); end
        checks++; if (math_enable !== 1'b0 || orient_valid !== 1'b0) begin fails++; $display("[TB] FAIL abort_pulses: got %b%b expected 00", math_enable, orient_valid); end
        reset = 1'b0; step();
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_stays_idle: got %b expected 0", busy); end
    endtask

    task automatic test_timeout();
        run_to_wait(12'h321, 12'h123);
        math_orientation = 5'd17; math_done = 1'b1; step();
        math_done = 1'b0; step();
        valid_pulses = 0;
        start = 1'b1; step(); start = 1'b0;
        loc_r_theta = 12'h050; loc_valid = 1'b1; step(); loc_valid = 1'b0;
`ifdef ORIENT_TIMEOUT_EN
        repeat (TMO - 1) step();
        checks++; if (move_req !== 1'b1) begin fails++; $display("[TB] FAIL tmo_before_move_req: got %b expected 1", move_req); end
        checks++; if (timeout_err !== 1'b0) begin fails++; $display("[TB] FAIL tmo_before_err: got %b expected 0", timeout_err); end
        step();
        checks++; if (timeout_err !== 1'b1) begin fails++; $display("[TB] FAIL tmo_err: got %b expected 1", timeout_err); end
        checks++; if (move_req !== 1'b0) begin fails++; $display("[TB] FAIL tmo_move_req: got %b expected 0", move_req); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL tmo_busy: got %b expected 0", busy); end
        checks++; if (orientation !== 5'd17) begin fails++; $display("[TB] FAIL tmo_orientation: got %0d expected 17", orientation); end
        step();
        checks++; if (timeout_err !== 1'b1) begin fails++; $display("[TB] FAIL tmo_sticky: got %b expected 1", timeout_err); end
        checks++; if (valid_pulses !== 0) begin fails++; $display("[TB] FAIL tmo_no_valid: got %0d expected 0", valid_pulses); end
        start = 1'b1; step(); start = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin fails++; $display("[TB] FAIL tmo_clear: got %b expected 0", timeout_err); end
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL tmo_restart: got %b expected 1", busy); end
`else
        repeat (TMO + 20) step();
        checks++; if (move_req !== 1'b1) begin fails++; $display("[TB] FAIL wait_move_req: got %b expected 1", move_req); end
        checks++; if (timeout_err !== 1'b0) begin fails++; $display("[TB] FAIL wait_err: got %b expected 0", timeout_err); end
        checks++; if (orientation !== 5'd17) begin fails++; $display("[TB] FAIL wait_orientation: got %0d expected 17", orientation); end
        checks++; if (valid_pulses !== 0) begin fails++; $display("[TB] FAIL wait_no_valid: got %0d expected 0", valid_pulses); end
`endif
        reset = 1'b1; step(); reset = 1'b0; step();
    endtask

    initial begin
        $display("[TB] orientation_sequencer directed tests");
        test_reset();
        test_basic();
        test_stale_done();
        test_range();
        test_ignored();
        test_reset_abort();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
